// File: rtl/icache_fetch_port_pkg.sv
// Shared constants and state encoding for the instruction cache fetch port.
package icache_fetch_port_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

    // IDLE: accepting lookups; WAIT: one memory request outstanding
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/icache_fetch_port_if.sv
// Fetcher / memory-controller / ROB signals seen by the cache.
// The slave modport is the cache's view; master is the surrounding system.
interface icache_fetch_port_if;
    import icache_fetch_port_pkg::*;

    logic                  in_fetch_ce;
    logic [DATA_WIDTH-1:0] in_fetch_pc;
    logic                  out_fetch_ready;
    logic [DATA_WIDTH-1:0] out_fetch_inst;
    logic                  out_mem_ce;
    logic [DATA_WIDTH-1:0] out_mem_addr;
    logic                  in_mem_ce;
    logic [DATA_WIDTH-1:0] in_mem_data;
    logic                  in_rob_misbranch;

    modport slave (
        input  in_fetch_ce,
        input  in_fetch_pc,
        output out_fetch_ready,
        output out_fetch_inst,
        output out_mem_ce,
        output out_mem_addr,
        input  in_mem_ce,
        input  in_mem_data,
        input  in_rob_misbranch
    );

    modport master (
        output in_fetch_ce,
        output in_fetch_pc,
        input  out_fetch_ready,
        input  out_fetch_inst,
        input  out_mem_ce,
        input  out_mem_addr,
        output in_mem_ce,
        output in_mem_data,
        output in_rob_misbranch
    );

endinterface

// File: rtl/icache_fetch_port_array.sv
// Valid/tag/data storage for the direct-mapped cache.
// Combinational lookup (index + tag -> hit, data), synchronous single write port.
// Only the valid bits are reset; tag/data contents are meaningless until valid.
module icache_array
    import icache_fetch_port_pkg::*;
#(
    parameter int INDEX_BITS = 8,
    parameter int TAG_BITS   = 22
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] i_rd_index,
    input  logic [TAG_BITS-1:0]   i_rd_tag,
    output logic                  o_rd_hit,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    input  logic                  i_we,
    input  logic [INDEX_BITS-1:0] i_wr_index,
    input  logic [TAG_BITS-1:0]   i_wr_tag,
    input  logic [DATA_WIDTH-1:0] i_wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]      r_valid;
    logic [TAG_BITS-1:0]   r_tag  [LINES];
    logic [DATA_WIDTH-1:0] r_data [LINES];

    // One flop per valid bit: cleared by reset, set when its line is filled
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid[gi] <= FALSE;
            end else if (i_we && (i_wr_index == INDEX_BITS'(gi))) begin
                r_valid[gi] <= TRUE;
            end
        end
    end

    // Tag and data fill on a write; no reset needed behind the valid bits
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    // Lookup is combinational so a hit can answer on the very next edge
    always_comb begin
        o_rd_hit  = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);
        o_rd_data = r_data[i_rd_index];
    end

endmodule

// File: rtl/icache_fetch_port.sv
// Direct-mapped, one-word-per-line instruction cache in front of the
// memory controller's fetcher port. Hits answer in one cycle; a miss issues
// a single word request and fills the line when the word comes back.
// A misbranch drops any pending miss without filling.
module icache_fetch_port
    import icache_fetch_port_pkg::*;
#(
    parameter int INDEX_BITS = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    icache_fetch_port_if.slave   fetch_bus
);

    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

    state_t                r_state;
    logic                  r_fetch_ready;
    logic [ADDR_WIDTH-1:0] r_fetch_inst;
    logic                  r_mem_ce;
    logic [ADDR_WIDTH-1:0] r_mem_addr;

    logic [INDEX_BITS-1:0] w_rd_index;
    logic [TAG_BITS-1:0]   w_rd_tag;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_we;
    logic [INDEX_BITS-1:0] w_wr_index;
    logic [TAG_BITS-1:0]   w_wr_tag;
    logic                  w_unused;

    // Lookup uses the live fetch pc; fill uses the latched request address
    always_comb begin
        w_rd_index = fetch_bus.in_fetch_pc[INDEX_BITS+1:2];
        w_rd_tag   = fetch_bus.in_fetch_pc[ADDR_WIDTH-1:INDEX_BITS+2];
        w_wr_index = r_mem_addr[INDEX_BITS+1:2];
        w_wr_tag   = r_mem_addr[ADDR_WIDTH-1:INDEX_BITS+2];
        // Fill only for the live miss; a stall, flush or stray response must not write
        w_we       = !rst && rdy && !fetch_bus.in_rob_misbranch
                     && (r_state == WAIT) && fetch_bus.in_mem_ce;
    end

    // Byte-offset bits of the word-aligned pc carry no information
    assign w_unused = ^fetch_bus.in_fetch_pc[1:0];

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .i_rd_index (w_rd_index),
        .i_rd_tag   (w_rd_tag),
        .o_rd_hit   (w_hit),
        .o_rd_data  (w_rd_data),
        .i_we       (w_we),
        .i_wr_index (w_wr_index),
        .i_wr_tag   (w_wr_tag),
        .i_wr_data  (fetch_bus.in_mem_data)
    );

    // Control FSM with registered outputs: reset > stall > flush > normal
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_fetch_ready <= FALSE;
            r_fetch_inst  <= ZERO_DATA;
            r_mem_ce      <= FALSE;
            r_mem_addr    <= ZERO_DATA;
        end else if (rdy) begin
            if (fetch_bus.in_rob_misbranch) begin
                r_state       <= IDLE;
                r_mem_ce      <= FALSE;
                r_fetch_ready <= FALSE;
            end else begin
                // Both handshake outputs are single-cycle pulses
                r_fetch_ready <= FALSE;
                r_mem_ce      <= FALSE;
                case (r_state)
                    IDLE: begin
                        // The cycle after an answer the request is still held; ignore it
                        if (!r_fetch_ready && fetch_bus.in_fetch_ce) begin
                            if (w_hit) begin
                                r_fetch_inst  <= w_rd_data;
                                r_fetch_ready <= TRUE;
                            end else begin
                                r_mem_addr <= fetch_bus.in_fetch_pc;
                                r_mem_ce   <= TRUE;
                                r_state    <= WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        if (fetch_bus.in_mem_ce) begin
                            r_fetch_inst  <= fetch_bus.in_mem_data;
                            r_fetch_ready <= TRUE;
                            r_state       <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign fetch_bus.out_fetch_ready = r_fetch_ready;
    assign fetch_bus.out_fetch_inst  = r_fetch_inst;
    assign fetch_bus.out_mem_ce      = r_mem_ce;
    assign fetch_bus.out_mem_addr    = r_mem_addr;

endmodule

// File: tb/tb_icache_fetch_port.sv
// Directed bench for icache_fetch_port: expected instructions and memory
// request addresses are queued when stimulus is driven and compared when
// the DUT raises out_fetch_ready / out_mem_ce.
module tb_icache_fetch_port;
    import icache_fetch_port_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb_inst [$];
    logic [31:0] sb_addr [$];

    icache_fetch_port_if bus ();

    icache_fetch_port #(
        .INDEX_BITS (8),
        .ADDR_WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .fetch_bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: compare each ready pulse / memory request as it appears
    always @(negedge clk) begin
        if (!rst && rdy) begin
            if (bus.out_fetch_ready) begin
                if (sb_inst.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    logic [31:0] e;
                    e = sb_inst.pop_front();
                    check("fetch_inst", bus.out_fetch_inst, e);
                    $display("fetch  inst=%h expected=%h", bus.out_fetch_inst, e);
                end
            end
            if (bus.out_mem_ce) begin
                if (sb_addr.size() == 0) begin
                    check("unexpected_mem_ce", 32'd1, 32'd0);
                end else begin
                    logic [31:0] e;
                    e = sb_addr.pop_front();
                    check("mem_addr", bus.out_mem_addr, e);
                    $display("memreq addr=%h expected=%h", bus.out_mem_addr, e);
                end
            end
        end
    end

    // Wait for out_fetch_ready; returns the number of edges it took (99 on timeout)
    task automatic wait_ready(output int cyc);
        cyc = 99;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.out_fetch_ready) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_mem(output int cyc);
        cyc = 99;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.out_mem_ce) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic do_hit(input logic [31:0] pc, input logic [31:0] data, input string tag);
        int cyc;
        sb_inst.push_back(data);
        bus.in_fetch_ce = 1'b1;
        bus.in_fetch_pc = pc;
        wait_ready(cyc);
        bus.in_fetch_ce = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'd1);
        tick();
        check({tag, "_ready_width"}, 32'(bus.out_fetch_ready), 32'd0);
    endtask

    // Miss: expect a request next edge, answer 4 cycles after the request pulse
    task automatic do_miss(input logic [31:0] pc, input logic [31:0] data, input string tag);
        int cyc;
        sb_addr.push_back(pc);
        bus.in_fetch_ce = 1'b1;
        bus.in_fetch_pc = pc;
        wait_mem(cyc);
        check({tag, "_req_latency"}, 32'(cyc), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check({tag, "_mem_ce_pulse"}, 32'(bus.out_mem_ce), 32'd0);
            check({tag, "_addr_hold"}, bus.out_mem_addr, pc);
            check({tag, "_no_early_ready"}, 32'(bus.out_fetch_ready), 32'd0);
        end
        sb_inst.push_back(data);
        bus.in_mem_ce   = 1'b1;
        bus.in_mem_data = data;
        tick();
        bus.in_mem_ce   = 1'b0;
        bus.in_mem_data = 32'h0;
        bus.in_fetch_ce = 1'b0;
        check({tag, "_fill_ready"}, 32'(bus.out_fetch_ready), 32'd1);
        tick();
        check({tag, "_ready_width"}, 32'(bus.out_fetch_ready), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, 32'(bus.out_fetch_ready), 32'd0);
        check({tag, "_inst"}, bus.out_fetch_inst, 32'd0);
        check({tag, "_mem_ce"}, 32'(bus.out_mem_ce), 32'd0);
        check({tag, "_mem_addr"}, bus.out_mem_addr, 32'd0);
    endtask

    initial begin
        int cyc;
        bus.in_fetch_ce      = 1'b0;
        bus.in_fetch_pc      = 32'h0;
        bus.in_mem_ce        = 1'b0;
        bus.in_mem_data      = 32'h0;
        bus.in_rob_misbranch = 1'b0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // Cold miss, then hit on the same line
        do_miss(32'h0000_0010, 32'h0051_0513, "cold_miss");
        do_hit(32'h0000_0010, 32'h0051_0513, "hit");

        // rdy stall between the hit request and its response edge
        sb_inst.push_back(32'h0051_0513);
        bus.in_fetch_ce = 1'b1;
        bus.in_fetch_pc = 32'h0000_0010;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_no_ready", 32'(bus.out_fetch_ready), 32'd0);
        end
        rdy = 1'b1;
        wait_ready(cyc);
        bus.in_fetch_ce = 1'b0;
        check("stall_latency", 32'(cyc), 32'd1);
        tick();
        check("stall_ready_width", 32'(bus.out_fetch_ready), 32'd0);

        // Conflict eviction: 0x410 shares the index of 0x10
        do_miss(32'h0000_0410, 32'hDEAD_BEEF, "conflict");
        do_miss(32'h0000_0010, 32'h0051_0513, "evicted");

        // Misbranch while waiting, then a stray response
        sb_addr.push_back(32'h0000_0020);
        bus.in_fetch_ce = 1'b1;
        bus.in_fetch_pc = 32'h0000_0020;
        wait_mem(cyc);
        check("mb_req_latency", 32'(cyc), 32'd1);
        tick();
        bus.in_rob_misbranch = 1'b1;
        tick();
        bus.in_rob_misbranch = 1'b0;
        bus.in_fetch_ce      = 1'b0;
        check("mb_ready", 32'(bus.out_fetch_ready), 32'd0);
        check("mb_mem_ce", 32'(bus.out_mem_ce), 32'd0);
        tick();
        tick();
        bus.in_mem_ce   = 1'b1;
        bus.in_mem_data = 32'h1111_1111;
        tick();
        bus.in_mem_ce   = 1'b0;
        bus.in_mem_data = 32'h0;
        check("stray_no_ready", 32'(bus.out_fetch_ready), 32'd0);
        tick();
        check("stray_no_ready2", 32'(bus.out_fetch_ready), 32'd0);
        do_miss(32'h0000_0020, 32'h2222_3333, "after_mb");

        // Reset while waiting for a miss to 0x30
        sb_addr.push_back(32'h0000_0030);
        bus.in_fetch_ce = 1'b1;
        bus.in_fetch_pc = 32'h0000_0030;
        wait_mem(cyc);
        check("rst_req_latency", 32'(cyc), 32'd1);
        tick();
        bus.in_fetch_ce = 1'b0;
        rst = 1'b1;
        tick();
        check_outputs_zero("mid_rst");
        rst = 1'b0;
        tick();
        do_miss(32'h0000_0010, 32'h0051_0513, "post_rst");

        tick();
        check("sb_inst_empty", 32'(sb_inst.size()), 32'd0);
        check("sb_addr_empty", 32'(sb_addr.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
